// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the M stage and the memory.
// The stage holds a request until ack or abort; the memory may answer with variable latency.
interface memory_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/memory_access_stage.sv
// RV32 pipeline M stage: drives the variable-latency data-memory bus, stalls upstream while an
// access is outstanding, aborts after MAX_WAIT wait cycles, and feeds the M->W register.
module memory_access_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    memory_access_stage_if.master dmem,
    output logic        StallM,
    output logic        mem_abort,
    output logic [31:0] ALUResultM_fb,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        access;
    logic        req_now;
    logic        abort_now;
    logic        complete;
    logic        load_done;
    logic [1:0]  result_src_eff;

    logic        reg_write_w_reg;
    logic [1:0]  result_src_w_reg;
    logic [31:0] alu_result_w_reg;
    logic [31:0] read_data_w_reg;
    logic [4:0]  rd_w_reg;
    logic [31:0] pc_plus4_w_reg;

    assign access         = MemWriteM | (ResultSrcM == 2'b01);
    assign result_src_eff = (ResultSrcM == 2'b11) ? 2'b00 : ResultSrcM;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        req_now       = 1'b0;
        abort_now     = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    req_now = access;
                    if (access && !dmem.dmem_ack) begin
                        state_next    = WAIT;
                        wait_cnt_next = 8'd1;
                    end
                end
                WAIT: begin
                    req_now = 1'b1;
                    if (dmem.dmem_ack) begin
                        state_next    = IDLE;
                        wait_cnt_next = 8'd0;
                    end else if (wait_cnt_reg == 8'(MAX_WAIT)) begin
                        abort_now     = 1'b1;
                        state_next    = IDLE;
                        wait_cnt_next = 8'd0;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // An ack only counts while a request is actually on the bus.
    assign complete  = req_now & dmem.dmem_ack;
    assign load_done = complete & ~MemWriteM & (ResultSrcM == 2'b01);
    assign StallM    = req_now & ~dmem.dmem_ack & ~abort_now;
    assign mem_abort = abort_now;

    assign dmem.dmem_req   = req_now;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_wdata = WriteDataM;
    assign ALUResultM_fb   = ALUResultM;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_addr
            if (gi < 2) begin : g_low
                assign dmem.dmem_addr[gi] = 1'b0;
            end else begin : g_high
                assign dmem.dmem_addr[gi] = ALUResultM[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_w_reg  <= 1'b0;
            result_src_w_reg <= 2'b00;
            alu_result_w_reg <= 32'd0;
            read_data_w_reg  <= 32'd0;
            rd_w_reg         <= 5'd0;
            pc_plus4_w_reg   <= 32'd0;
        end else if (StallM) begin
            reg_write_w_reg  <= 1'b0;
            result_src_w_reg <= 2'b00;
        end else begin
            reg_write_w_reg  <= RegWriteM & ~abort_now;
            result_src_w_reg <= result_src_eff;
            alu_result_w_reg <= ALUResultM;
            rd_w_reg         <= RdM;
            pc_plus4_w_reg   <= PCPlus4M;
            if (load_done) begin
                read_data_w_reg <= dmem.dmem_rdata;
            end
        end
    end

    // W outputs read as zero while reset is asserted, not only after the clearing edge.
    assign RegWriteW  = reg_write_w_reg & ~reset;
    assign ResultSrcW = reset ? 2'b00 : result_src_w_reg;
    assign ALUResultW = reset ? 32'd0 : alu_result_w_reg;
    assign ReadDataW  = reset ? 32'd0 : read_data_w_reg;
    assign RdW        = reset ? 5'd0  : rd_w_reg;
    assign PCPlus4W   = reset ? 32'd0 : pc_plus4_w_reg;

endmodule
